// File: rtl/tip_clock_pll_div_pkg.sv
// Shared constants and DIV_LIST field extraction for the tip_clock_pll_div clock manager.
package tip_clock_pll_div_pkg;

  localparam int unsigned NUM_CLK_MAX      = 8;
  localparam int unsigned FIELD_MAX_W      = 32;
  localparam int unsigned LIST_MAX_W       = NUM_CLK_MAX * FIELD_MAX_W;
  localparam logic [15:0] DEFAULT_DIV_LIST = {8'd2, 8'd1};

  // Extract divide ratio field idx (width w); a zero ratio behaves as a pass-through (1).
  function automatic int unsigned div_field(input logic [LIST_MAX_W-1:0] list,
                                            input int unsigned           idx,
                                            input int unsigned           w);
    logic [LIST_MAX_W-1:0] shifted;
    logic [63:0]           mask;
    int unsigned           d;
    shifted = list >> (idx * w);
    mask    = (64'd1 << w) - 64'd1;
    d       = 32'(shifted[63:0] & mask);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/tip_clock_pll_div_if.sv
// Output clock/reset bundle of tip_clock_pll_div; clk_gate_en exists only with TIP_CLOCK_PLL_DIV_GATE_EN.
interface tip_clock_pll_div_if #(
  parameter int unsigned NUM_CLK = 2
);

  logic [NUM_CLK-1:0] clk_out;
  logic [NUM_CLK-1:0] rstnn_out;
  logic               locked;
`ifdef TIP_CLOCK_PLL_DIV_GATE_EN
  logic [NUM_CLK-1:0] clk_gate_en;
`endif

  modport master (
`ifdef TIP_CLOCK_PLL_DIV_GATE_EN
    input  clk_gate_en,
`endif
    output clk_out,
    output rstnn_out,
    output locked
  );

  modport slave (
`ifdef TIP_CLOCK_PLL_DIV_GATE_EN
    output clk_gate_en,
`endif
    input  clk_out,
    input  rstnn_out,
    input  locked
  );

endinterface

// File: rtl/tip_clock_pll_div_channel.sv
// One output channel: divider counter with duty decode, optional gate (TIP_CLOCK_PLL_DIV_GATE_EN),
// and a reset synchroniser clocked by the channel's own output clock.
module tip_clock_pll_div_channel #(
  parameter int unsigned DIV             = 1,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter int unsigned RST_SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic sync_rst_ni,
`ifdef TIP_CLOCK_PLL_DIV_GATE_EN
  input  logic gate_en_i,
`endif
  output logic clk_o,
  output logic rstnn_o
);

  logic gate;
`ifdef TIP_CLOCK_PLL_DIV_GATE_EN
  assign gate = gate_en_i;
`else
  assign gate = 1'b1;
`endif

  if (DIV <= 1) begin : g_bypass
    logic gate_q;

    // Sampled while external clock is low, so a gate change never truncates a high phase.
    always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) gate_q <= 1'b0;
      else         gate_q <= gate;
    end

    assign clk_o = clk_i & en_i & gate_q;
  end else begin : g_div
    localparam int unsigned HIGH = (DIV + 1) / 2;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clk_q, clk_d;

    // Output is registered one step ahead of the count so rising edges land on external_clk posedges.
    always_comb begin
      cnt_d = cnt_q;
      clk_d = clk_q;
      if (en_i) begin
        cnt_d = (cnt_q == CNT_WIDTH'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        if (cnt_q == '0)                       clk_d = gate;
        else if (cnt_q >= CNT_WIDTH'(HIGH))    clk_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        clk_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        clk_q <= clk_d;
      end
    end

    assign clk_o = clk_q;
  end

  logic [RST_SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_o or negedge sync_rst_ni) begin
    if (!sync_rst_ni) sync_q <= '0;
    else              sync_q <= (sync_q << 1) | RST_SYNC_STAGES'(1);
  end

  assign rstnn_o = sync_q[RST_SYNC_STAGES-1];

endmodule

// File: rtl/tip_clock_pll_div.sv
// Simulation clock manager: lock-delay model plus NUM_CLK rising-edge-aligned divided clocks with
// per-domain synchronised resets. Optional per-channel gating via TIP_CLOCK_PLL_DIV_GATE_EN.
module tip_clock_pll_div
  import tip_clock_pll_div_pkg::*;
#(
  parameter int unsigned                   NUM_CLK         = 2,
  parameter int unsigned                   CNT_WIDTH       = 8,
  parameter logic [NUM_CLK*CNT_WIDTH-1:0]  DIV_LIST        = DEFAULT_DIV_LIST,
  parameter int unsigned                   LOCK_CYCLES     = 16,
  parameter int unsigned                   RST_SYNC_STAGES = 2
) (
  input  logic                   external_clk,
  input  logic                   external_rstnn,
  tip_clock_pll_div_if.master    pll_if
);

  localparam int unsigned           LCW          = $clog2(LOCK_CYCLES + 1);
  localparam logic [LIST_MAX_W-1:0] DIV_LIST_EXT = LIST_MAX_W'(DIV_LIST);

  logic [LCW-1:0]     lock_cnt_q, lock_cnt_d;
  logic               locked;
  logic               en_q;
  logic               sync_rstn;
  logic [NUM_CLK-1:0] clk_vec;
  logic [NUM_CLK-1:0] rstnn_vec;

  // Saturating counter; locked is a pure decode of it and therefore sticky until reset.
  assign locked = (lock_cnt_q == LCW'(LOCK_CYCLES));

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!locked) lock_cnt_d = lock_cnt_q + 1'b1;
  end

  always_ff @(posedge external_clk or negedge external_rstnn) begin
    if (!external_rstnn) lock_cnt_q <= '0;
    else                 lock_cnt_q <= lock_cnt_d;
  end

  always_ff @(negedge external_clk or negedge external_rstnn) begin
    if (!external_rstnn) en_q <= 1'b0;
    else                 en_q <= locked;
  end

  assign sync_rstn = external_rstnn & locked;

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_ch
    tip_clock_pll_div_channel #(
      .DIV             (div_field(DIV_LIST_EXT, i, CNT_WIDTH)),
      .CNT_WIDTH       (CNT_WIDTH),
      .RST_SYNC_STAGES (RST_SYNC_STAGES)
    ) u_ch (
      .clk_i       (external_clk),
      .rst_ni      (external_rstnn),
      .en_i        (en_q),
      .sync_rst_ni (sync_rstn),
`ifdef TIP_CLOCK_PLL_DIV_GATE_EN
      .gate_en_i   (pll_if.clk_gate_en[i]),
`endif
      .clk_o       (clk_vec[i]),
      .rstnn_o     (rstnn_vec[i])
    );
  end

  assign pll_if.clk_out   = clk_vec;
  assign pll_if.rstnn_out = rstnn_vec;
  assign pll_if.locked    = locked;

endmodule

// File: tb/tb_tip_clock_pll_div.sv
// Scoreboard bench for tip_clock_pll_div: channels D = 1,2,3,4,0 against a cycle-count reference model.
module tb_tip_clock_pll_div;

  localparam int unsigned N = 5;
  localparam int unsigned L = 16;
  localparam int unsigned S = 2;

  int unsigned divs [N] = '{1, 2, 3, 4, 0};

  typedef struct {
    int          t;
    bit          hi;
    logic [N-1:0] clk;
    logic [N-1:0] rst;
    logic        lk;
  } exp_t;

  logic clk;
  logic rstn;
  int   t;
  int   total;
  int   passed;
  exp_t q[$];

  tip_clock_pll_div_if #(.NUM_CLK(N)) pll_if ();

  tip_clock_pll_div #(
    .NUM_CLK         (N),
    .CNT_WIDTH       (8),
    .DIV_LIST        ({8'd0, 8'd4, 8'd3, 8'd2, 8'd1}),
    .LOCK_CYCLES     (L),
    .RST_SYNC_STAGES (S)
  ) dut (
    .external_clk   (clk),
    .external_rstnn (rstn),
    .pll_if         (pll_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: t = external_clk posedges since reset release (0 while in reset).
  function automatic exp_t model(input int tc, input bit hi);
    exp_t e;
    int   d;
    int   u;
    int   edges;
    e.t   = tc;
    e.hi  = hi;
    e.clk = '0;
    e.rst = '0;
    e.lk  = (tc >= int'(L));
    for (int i = 0; i < int'(N); i++) begin
      d = (divs[i] == 0) ? 1 : int'(divs[i]);
      if (tc > int'(L)) begin
        u = tc - int'(L) - 1;
        if (d == 1) begin
          e.clk[i] = hi;
          edges    = tc - int'(L);
        end else begin
          e.clk[i] = ((u % d) < ((d + 1) / 2));
          edges    = u / d + 1;
        end
        e.rst[i] = (edges >= int'(S));
      end
    end
    return e;
  endfunction

  function automatic bit d4_high(input int tc);
    return (tc > int'(L)) && (((tc - int'(L) - 1) % 4) < 2);
  endfunction

  function automatic bit drop_ok(input int tc, input int target);
    return (tc >= target) && ((tc <= int'(L)) || d4_high(tc));
  endfunction

  // One external_clk cycle: push expectations for the high and low phase samples.
  task automatic step(input bit drop, input bit release_rst);
    @(posedge clk);
    if (rstn) t++;
    if (drop || !rstn) begin
      q.push_back(model(0, 1'b1));
      q.push_back(model(0, 1'b0));
    end else begin
      q.push_back(model(t, 1'b1));
      q.push_back(model(t, 1'b0));
    end
    if (drop) begin
      #3 rstn = 1'b0;
    end
    if (release_rst) begin
      #6 rstn = 1'b1;
      t = 0;
    end
  endtask

  task automatic check_sample();
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    total++;
    if (pll_if.clk_out === e.clk) passed++;
    else $display("FAIL clk_out t=%0d hi=%0d got %b want %b", e.t, e.hi, pll_if.clk_out, e.clk);
    total++;
    if (pll_if.rstnn_out === e.rst) passed++;
    else $display("FAIL rstnn_out t=%0d hi=%0d got %b want %b", e.t, e.hi, pll_if.rstnn_out, e.rst);
    total++;
    if (pll_if.locked === e.lk) passed++;
    else $display("FAIL locked t=%0d hi=%0d got %b want %b", e.t, e.hi, pll_if.locked, e.lk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #4 check_sample();
      @(negedge clk);
      #4 check_sample();
    end
  end

  initial begin
    int target;
    int guard;
    total  = 0;
    passed = 0;
    t      = 0;
    rstn   = 1'b0;
`ifdef TIP_CLOCK_PLL_DIV_GATE_EN
    pll_if.clk_gate_en = '1;
`endif
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    for (int it = 0; it < 7; it++) begin
      target = (it == 0) ? 60 : int'($urandom_range(4, 70));
      guard  = 0;
      while (!drop_ok(t + 1, target) && guard < 200) begin
        step(1'b0, 1'b0);
        guard++;
      end
      step(1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end

    repeat (40) step(1'b0, 1'b0);

    guard = 0;
    while (q.size() != 0 && guard < 4) begin
      @(posedge clk);
      guard++;
    end
    #6;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain left %0d entries, required 0", q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
